// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Width of a register-file index
    localparam int REG_SEL_W = 5;

    // Controller sequencing states
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        BR_SHADOW = 2'd2,
        MEM_WAIT  = 2'd3
    } hz_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline status in / stall-flush controls and counters out
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_SEL_W-1:0] de_reg_1_sel;
    logic [REG_SEL_W-1:0] de_reg_2_sel;
    logic                 de_reg_1_used;
    logic                 de_reg_2_used;
    logic                 ex_mem_en;
    logic                 ex_mem_wrt;
    logic                 ex_reg_wrt_en;
    logic [REG_SEL_W-1:0] ex_reg_wrt_sel;
    logic                 ex_redirect;
    logic                 mem_busy;
    logic                 ctr_clr;
    logic                 pc_stall;
    logic                 fede_stall;
    logic                 fede_flush;
    logic                 deex_stall;
    logic                 deex_flush;
    logic                 exmem_stall;
    logic                 memwb_stall;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic [CNT_W-1:0]     lu_cnt;

    // Controller side
    modport slave (
        input  de_reg_1_sel, de_reg_2_sel, de_reg_1_used, de_reg_2_used,
        input  ex_mem_en, ex_mem_wrt, ex_reg_wrt_en, ex_reg_wrt_sel,
        input  ex_redirect, mem_busy, ctr_clr,
        output pc_stall, fede_stall, fede_flush, deex_stall, deex_flush,
        output exmem_stall, memwb_stall, stall_cnt, flush_cnt, lu_cnt
    );

    // Pipeline side
    modport master (
        output de_reg_1_sel, de_reg_2_sel, de_reg_1_used, de_reg_2_used,
        output ex_mem_en, ex_mem_wrt, ex_reg_wrt_en, ex_reg_wrt_sel,
        output ex_redirect, mem_busy, ctr_clr,
        input  pc_stall, fede_stall, fede_flush, deex_stall, deex_flush,
        input  exmem_stall, memwb_stall, stall_cnt, flush_cnt, lu_cnt
    );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with synchronous clear
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         inc,
    input  wire logic         clr,
    output logic [W-1:0]      cnt
);

    logic [W-1:0] r_cnt;

    // Clear wins over increment; sticks at all-ones once reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, redirect flush and memory-freeze sequencing
//               for the pipeline registers, with performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYCLES    = 1,
    parameter int CNT_W              = 16,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave bus
);

    // Bubble counter only needs to hold LU_STALL_CYCLES-2
    localparam int                c_LU_W      = (LU_STALL_CYCLES > 2) ? $clog2(LU_STALL_CYCLES - 1) : 1;
    localparam int                c_LU_LOAD_I = (LU_STALL_CYCLES > 1) ? LU_STALL_CYCLES - 2 : 0;
    localparam logic [c_LU_W-1:0] c_LU_LOAD   = c_LU_W'(c_LU_LOAD_I);

    hz_state_t         r_state, w_state_nxt;
    hz_state_t         r_ret_state, w_ret_nxt;
    hz_state_t         w_eff_state;
    logic              r_redirect_pend, w_pend_nxt;
    logic [c_LU_W-1:0] r_lu_cnt, w_lu_nxt;

    logic w_dest_ok, w_lu_hit, w_redirect;
    logic w_pc_stall, w_fede_stall, w_fede_flush, w_deex_stall, w_deex_flush;
    logic w_exmem_stall, w_memwb_stall;
    logic w_flush_inc, w_lu_inc;

    assign w_dest_ok = (bus.ex_reg_wrt_sel != '0) || (ZERO_REG_HARDWIRED == 0);
    assign w_lu_hit  = bus.ex_mem_en && !bus.ex_mem_wrt && bus.ex_reg_wrt_en && w_dest_ok &&
                       ((bus.de_reg_1_used && (bus.de_reg_1_sel == bus.ex_reg_wrt_sel)) ||
                        (bus.de_reg_2_used && (bus.de_reg_2_sel == bus.ex_reg_wrt_sel)));

    // Once memory releases, MEM_WAIT behaves as the state it interrupted
    assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

    // Next-state and same-cycle stall/flush decode: busy > redirect > load-use
    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret_state;
        w_pend_nxt    = r_redirect_pend;
        w_lu_nxt      = r_lu_cnt;
        w_redirect    = 1'b0;
        w_pc_stall    = 1'b0;
        w_fede_stall  = 1'b0;
        w_fede_flush  = 1'b0;
        w_deex_stall  = 1'b0;
        w_deex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_stall = 1'b0;
        w_flush_inc   = 1'b0;
        w_lu_inc      = 1'b0;

        if (bus.mem_busy) begin
            w_pc_stall    = 1'b1;
            w_fede_stall  = 1'b1;
            w_deex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_stall = 1'b1;
            w_state_nxt   = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_ret_nxt = r_state;
            end
            // Redirect seen during the freeze is remembered; the shadow bubble never redirects
            if (bus.ex_redirect && (w_eff_state != BR_SHADOW)) begin
                w_pend_nxt = 1'b1;
            end
        end else begin
            w_redirect = r_redirect_pend || (bus.ex_redirect && (w_eff_state != BR_SHADOW));
            if (w_redirect) begin
                // Flush also kills any load-use dependent in Decode
                w_fede_flush = 1'b1;
                w_deex_flush = 1'b1;
                w_pend_nxt   = 1'b0;
                w_flush_inc  = 1'b1;
                w_state_nxt  = BR_SHADOW;
            end else begin
                case (w_eff_state)
                    BR_SHADOW: begin
                        w_state_nxt = RUN;
                    end
                    LU_STALL: begin
                        w_pc_stall   = 1'b1;
                        w_fede_stall = 1'b1;
                        w_deex_flush = 1'b1;
                        if (r_lu_cnt == '0) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = LU_STALL;
                            w_lu_nxt    = r_lu_cnt - 1'b1;
                        end
                    end
                    default: begin
                        w_state_nxt = RUN;
                        if (w_lu_hit) begin
                            w_pc_stall   = 1'b1;
                            w_fede_stall = 1'b1;
                            w_deex_flush = 1'b1;
                            w_lu_inc     = 1'b1;
                            if (LU_STALL_CYCLES > 1) begin
                                w_lu_nxt    = c_LU_LOAD;
                                w_state_nxt = LU_STALL;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Sequencing state, interrupted state, pending redirect and bubble count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= RUN;
            r_ret_state     <= RUN;
            r_redirect_pend <= 1'b0;
            r_lu_cnt        <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_ret_state     <= w_ret_nxt;
            r_redirect_pend <= w_pend_nxt;
            r_lu_cnt        <= w_lu_nxt;
        end
    end

    // Controls are forced quiet while reset is asserted, whatever the inputs
    assign bus.pc_stall    = w_pc_stall    & rst_n;
    assign bus.fede_stall  = w_fede_stall  & rst_n;
    assign bus.fede_flush  = w_fede_flush  & rst_n;
    assign bus.deex_stall  = w_deex_stall  & rst_n;
    assign bus.deex_flush  = w_deex_flush  & rst_n;
    assign bus.exmem_stall = w_exmem_stall & rst_n;
    assign bus.memwb_stall = w_memwb_stall & rst_n;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pc_stall),
        .clr   (bus.ctr_clr),
        .cnt   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .clr   (bus.ctr_clr),
        .cnt   (bus.flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_lu_inc),
        .clr   (bus.ctr_clr),
        .cnt   (bus.lu_cnt)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl; two instances (1-cycle and
//               3-cycle load-use, 16-bit and 4-bit counters) share stimulus
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    typedef struct {
        logic [6:0] outs;   // {pc, fede_stall, fede_flush, deex_stall, deex_flush, exmem, memwb}
        int         sc;
        int         fc;
        int         lc;
    } exp_t;

    localparam int LU_C [2] = '{1, 3};
    localparam int MAX_C[2] = '{65535, 15};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] r1s, r2s, wsel;
    logic       u1, u2, men, mwrt, wen, redir, busy, clr;

    int checks = 0;
    int passed = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model context per instance
    int m_rem   [2];
    int m_sc    [2];
    int m_fc    [2];
    int m_lc    [2];
    bit m_shadow[2];
    bit m_pend  [2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    hazard_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_a.de_reg_1_sel   = r1s;   assign bus_b.de_reg_1_sel   = r1s;
    assign bus_a.de_reg_2_sel   = r2s;   assign bus_b.de_reg_2_sel   = r2s;
    assign bus_a.de_reg_1_used  = u1;    assign bus_b.de_reg_1_used  = u1;
    assign bus_a.de_reg_2_used  = u2;    assign bus_b.de_reg_2_used  = u2;
    assign bus_a.ex_mem_en      = men;   assign bus_b.ex_mem_en      = men;
    assign bus_a.ex_mem_wrt     = mwrt;  assign bus_b.ex_mem_wrt     = mwrt;
    assign bus_a.ex_reg_wrt_en  = wen;   assign bus_b.ex_reg_wrt_en  = wen;
    assign bus_a.ex_reg_wrt_sel = wsel;  assign bus_b.ex_reg_wrt_sel = wsel;
    assign bus_a.ex_redirect    = redir; assign bus_b.ex_redirect    = redir;
    assign bus_a.mem_busy       = busy;  assign bus_b.mem_busy       = busy;
    assign bus_a.ctr_clr        = clr;   assign bus_b.ctr_clr        = clr;

    hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16), .ZERO_REG_HARDWIRED(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4), .ZERO_REG_HARDWIRED(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Expected response for this cycle's inputs; advances the model one cycle
    function automatic exp_t model_step(int d);
        exp_t       e;
        logic [6:0] o;
        bit         hit, sinc, finc, linc;
        o    = 7'b0;
        sinc = 0; finc = 0; linc = 0;
        e.sc = m_sc[d]; e.fc = m_fc[d]; e.lc = m_lc[d];
        if (!rst_n) begin
            m_rem[d] = 0; m_sc[d] = 0; m_fc[d] = 0; m_lc[d] = 0;
            m_shadow[d] = 0; m_pend[d] = 0;
            e.outs = 7'b0; e.sc = 0; e.fc = 0; e.lc = 0;
            return e;
        end
        hit = men && !mwrt && wen && (wsel != 5'd0) &&
              ((u1 && r1s == wsel) || (u2 && r2s == wsel));
        if (busy) begin
            o = 7'b1101011; sinc = 1;
            if (redir && !m_shadow[d]) m_pend[d] = 1;
        end else if (m_pend[d] || (redir && !m_shadow[d])) begin
            o = 7'b0010100; finc = 1;
            m_pend[d] = 0; m_shadow[d] = 1; m_rem[d] = 0;
        end else if (m_shadow[d]) begin
            m_shadow[d] = 0;
        end else if (m_rem[d] > 0) begin
            o = 7'b1100100; sinc = 1;
            m_rem[d] = m_rem[d] - 1;
        end else if (hit) begin
            o = 7'b1100100; sinc = 1; linc = 1;
            m_rem[d] = LU_C[d] - 1;
        end
        if (clr) begin
            m_sc[d] = 0; m_fc[d] = 0; m_lc[d] = 0;
        end else begin
            if (sinc && m_sc[d] < MAX_C[d]) m_sc[d]++;
            if (finc && m_fc[d] < MAX_C[d]) m_fc[d]++;
            if (linc && m_lc[d] < MAX_C[d]) m_lc[d]++;
        end
        e.outs = o;
        return e;
    endfunction

    // One stimulus cycle: drive just after the edge and queue expectations
    task automatic cyc(input logic rs, input logic [4:0] a1, input logic [4:0] a2,
                       input logic a1u, input logic a2u, input logic me, input logic mw,
                       input logic we, input logic [4:0] ws, input logic rd,
                       input logic bz, input logic cl);
        @(posedge clk);
        #1;
        rst_n = rs; r1s = a1; r2s = a2; u1 = a1u; u2 = a2u; men = me; mwrt = mw;
        wen = we; wsel = ws; redir = rd; busy = bz; clr = cl;
        q0.push_back(model_step(0));
        q1.push_back(model_step(1));
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Load to r5 in Execute, Decode reads r5 through source 2
    task automatic lu5(input logic rd, input logic bz, input logic cl);
        cyc(1, 5'd3, 5'd5, 1, 1, 1, 0, 1, 5'd5, rd, bz, cl);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("a_ctrl", int'({bus_a.pc_stall, bus_a.fede_stall, bus_a.fede_flush, bus_a.deex_stall,
                                bus_a.deex_flush, bus_a.exmem_stall, bus_a.memwb_stall}), int'(e.outs));
            chk("a_stall_cnt", int'(bus_a.stall_cnt), e.sc);
            chk("a_flush_cnt", int'(bus_a.flush_cnt), e.fc);
            chk("a_lu_cnt",    int'(bus_a.lu_cnt),    e.lc);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("b_ctrl", int'({bus_b.pc_stall, bus_b.fede_stall, bus_b.fede_flush, bus_b.deex_stall,
                                bus_b.deex_flush, bus_b.exmem_stall, bus_b.memwb_stall}), int'(e.outs));
            chk("b_stall_cnt", int'(bus_b.stall_cnt), e.sc);
            chk("b_flush_cnt", int'(bus_b.flush_cnt), e.fc);
            chk("b_lu_cnt",    int'(bus_b.lu_cnt),    e.lc);
        end
    end

    initial begin
        rst_n = 0; r1s = 0; r2s = 0; u1 = 0; u2 = 0; men = 0; mwrt = 0;
        wen = 0; wsel = 0; redir = 0; busy = 0; clr = 0;

        // Reset state, with a hazard pattern present to show outputs stay quiet
        cyc(0, 5'd3, 5'd5, 1, 1, 1, 0, 1, 5'd5, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) idle();

        // Load-use on r5 via source 2, then idle long enough for the 3-cycle instance
        lu5(0, 0, 0);
        repeat (4) idle();

        // r0 destination and stores never stall
        cyc(1, 5'd0, 5'd0, 1, 1, 1, 0, 1, 5'd0, 0, 0, 0);
        cyc(1, 5'd5, 5'd5, 1, 1, 1, 1, 1, 5'd5, 0, 0, 0);
        cyc(1, 5'd5, 5'd5, 0, 0, 1, 0, 1, 5'd5, 0, 0, 0);
        idle();

        // Redirect together with load-use, redirect held into the shadow cycle
        lu5(1, 0, 0);
        lu5(1, 0, 0);
        repeat (3) idle();

        // Four busy cycles with a redirect pulse in the second
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (3) idle();

        // Busy in the middle of a 3-cycle load-use sequence
        lu5(0, 0, 0);
        lu5(0, 1, 0);
        repeat (2) lu5(0, 1, 0);
        repeat (4) idle();

        // Reset dropped mid load-use stall
        lu5(0, 0, 0);
        cyc(0, 5'd3, 5'd5, 1, 1, 1, 0, 1, 5'd5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) idle();

        // Continuous hazards saturate the narrow counters, then clear during an increment
        repeat (60) lu5(0, 0, 0);
        lu5(0, 0, 1);
        repeat (3) idle();

        // Randomised traffic with a small register window so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 49) == 0));
        end
        idle();

        @(negedge clk);
        #2;
        chk("queues_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and flush controller that produces the per-register stall and flush controls for the CPU pipeline registers, including the Decode/Execute register's flush input. Consumes Decode-stage source selects plus the Decode/Execute outputs (memory and writeback control), branch/jump resolution from Execute, and the data-memory busy signal. Sequences load-use stalls, taken-branch flushes and memory freezes with a small FSM. Keeps saturating event counters for performance debug.

Parameters:
LU_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (>=1)
CNT_W, 16, width of each performance counter
ZERO_REG_HARDWIRED, 1, when 1 register 0 never causes a hazard

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
de_reg_1_sel  input  5  source register 1 of instruction in Decode
de_reg_2_sel  input  5  source register 2 of instruction in Decode
de_reg_1_used  input  1  Decode instruction reads source 1
de_reg_2_used  input  1  Decode instruction reads source 2
ex_mem_en  input  1  Execute-stage instruction accesses memory (DeEx output)
ex_mem_wrt  input  1  Execute-stage memory access is a store
ex_reg_wrt_en  input  1  Execute-stage instruction writes a register
ex_reg_wrt_sel  input  5  Execute-stage destination register
ex_redirect  input  1  Execute resolved taken branch or jump this cycle
mem_busy  input  1  data memory not ready; whole pipe must freeze
ctr_clr  input  1  synchronous clear of all counters
pc_stall  output  1  hold PC
fede_stall  output  1  hold Fetch/Decode register
fede_flush  output  1  clear Fetch/Decode register to NOP
deex_stall  output  1  hold Decode/Execute register
deex_flush  output  1  clear Decode/Execute register to NOP
exmem_stall  output  1  hold Execute/Memory register
memwb_stall  output  1  hold Memory/Writeback register
stall_cnt  output  CNT_W  cycles with pc_stall high
flush_cnt  output  CNT_W  redirect flushes applied
lu_cnt  output  CNT_W  load-use hazards detected

Behaviour:
- Async reset: state RUN, redirect_pend 0, lu counter 0, all counters 0; every stall/flush output 0 while rst_n low.
- Stall/flush outputs are combinational from state and current inputs (same-cycle effect); state, pending flag and counters are registered.
- lu_hit = ex_mem_en & ~ex_mem_wrt & ex_reg_wrt_en & (dest!=0 or ZERO_REG_HARDWIRED==0) & ((de_reg_1_used & de_reg_1_sel==ex_reg_wrt_sel) | (de_reg_2_used & de_reg_2_sel==ex_reg_wrt_sel)).
- Priority each cycle: mem_busy > redirect (ex_redirect or redirect_pend) > lu_hit > none.
- States:
  - RUN, no event: all outputs 0.
  - RUN + lu_hit: pc_stall, fede_stall, deex_flush = 1. If LU_STALL_CYCLES>1, load lu counter with LU_STALL_CYCLES-2 and go to LU_STALL; else stay in RUN.
  - LU_STALL: same outputs as the lu_hit cycle, without re-evaluating lu_hit. Return to RUN when the counter is 0, otherwise decrement.
  - Redirect in RUN or LU_STALL: fede_flush = deex_flush = 1, all stalls 0, clear redirect_pend, go to BR_SHADOW.
  - BR_SHADOW (exactly 1 cycle): ex_redirect and lu_hit are ignored because Execute holds a bubble. All outputs 0. Next state is RUN.
  - mem_busy in any state: pc/fede/deex/exmem/memwb stalls = 1, no flushes. Save current state in ret_state and go to MEM_WAIT.
  - MEM_WAIT: ex_redirect high sets redirect_pend. While mem_busy is high, hold all stalls. When mem_busy falls, go to ret_state; LU counter is frozen, not reloaded. A pending redirect is applied in that first non-busy cycle.
- A load-use in the same cycle as a redirect is discarded, because the redirect flush kills the dependent instruction.
- Counters saturate at all-ones. ctr_clr has priority over increment. Counter increments:
  - stall_cnt: +1 per pc_stall cycle.
  - flush_cnt: +1 per redirect applied.
  - lu_cnt: +1 per RUN lu_hit cycle (once per hazard).

Decomposition:
- hazard_pkg: state enum (RUN, LU_STALL, BR_SHADOW, MEM_WAIT) and the reg-index width constant REG_SEL_W=5.
- One sub-module, sat_counter (parameter W; inputs inc, clr; async active-low reset), instantiated three times.

Test Plan:
1. Load into r5 in Execute, Decode reads r5 via src2 (LU_STALL_CYCLES=1) -> one cycle with pc_stall=fede_stall=deex_flush=1, next cycle all 0, lu_cnt=1, stall_cnt=1.
2. Same with LU_STALL_CYCLES=3 -> exactly 3 consecutive stall+bubble cycles, lu_cnt=1, stall_cnt=3.
3. Dest r0, Decode reads r0, ZERO_REG_HARDWIRED=1 -> no stall. Store to r5 (ex_mem_wrt=1) -> no stall.
4. ex_redirect pulse together with lu_hit -> fede_flush=deex_flush=1, no stall. ex_redirect held the next cycle (BR_SHADOW) is ignored. flush_cnt=1.
5. mem_busy high for 4 cycles with an ex_redirect pulse in cycle 2 -> all five stalls high for 4 cycles, no flush. The cycle after is a flush cycle, flush_cnt=1.
6. rst_n dropped mid-LU_STALL -> outputs 0 immediately, counters 0, state RUN after release. Counter at 0xFFFF plus another stall stays 0xFFFF. ctr_clr together with an increment gives 0.
